param_const_timer: RTL and testbench

// - Periodic down-count timer whose reload period is an elaboration-time constant, the same

---
 rtl/param_const_timer_pkg.sv | 11 +
 rtl/param_const_timer_down_counter.sv | 36 +++
 rtl/param_const_timer.sv | 100 ++++++++++
 tb/tb_param_const_timer.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/param_const_timer_pkg.sv
// Purpose: shared types for param_const_timer.
//   state_t : timer FSM state (IDLE, RUN, HOLD), 2-bit encoding.
package param_const_timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/param_const_timer_down_counter.sv
// Purpose: nbits-wide down counter used by param_const_timer.
// Ports:
//   clk, reset   : clock, asynchronous active-low reset (count -> 0)
//   clear        : synchronous clear to 0 (highest priority)
//   load, load_value : load a new count
//   dec          : decrement by one; saturates at 0, never wraps
//   count        : current count
//   is_one       : count == 1 (last decrement before reaching zero)
module param_down_counter #(
  parameter int unsigned nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic [nbits-1:0] load_value,
  input  logic             dec,
  output logic [nbits-1:0] count,
  output logic             is_one
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - nbits'(1);
    end
  end

  assign is_one = (count == nbits'(1));

endmodule

// File: rtl/param_const_timer.sv
// Purpose: periodic down-count timer reloading an elaboration-time constant.
//   start loads count=value and runs; at zero an expire event is held on a
//   val/rdy interface until consumed.
//   Build option: PARAM_CONST_TIMER_AUTO_RELOAD_EN -- when defined the expire
//   handshake reloads and keeps running; otherwise it returns to IDLE.
// Ports:
//   clk        : clock
//   reset      : asynchronous active-low reset
//   start      : load count=value and enter RUN (also restarts RUN/HOLD)
//   stop       : abort to IDLE from any state (beats start)
//   count      : current count value
//   running    : state != IDLE
//   expire_val : expire event pending (state == HOLD)
//   expire_rdy : consumer accepts the expire event
module param_const_timer
  import param_const_timer_pkg::*;
#(
  parameter int unsigned nbits = 8,
  parameter int unsigned value = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  output logic [nbits-1:0] count,
  output logic             running,
  output logic             expire_val,
  input  logic             expire_rdy
);

  if (value == 0 || value >= (64'd1 << nbits)) begin : g_bad_value
    $error("param_const_timer: value must be in 1 .. 2**nbits-1");
  end

  localparam logic [nbits-1:0] RELOAD = nbits'(value);

  state_t state, state_next;
  logic   ctr_clear, ctr_load, ctr_dec, ctr_is_one;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ctr_clear  = 1'b0;
    ctr_load   = 1'b0;
    ctr_dec    = 1'b0;
    if (stop) begin
      state_next = IDLE;
      ctr_clear  = 1'b1;
    end else if (start) begin
      state_next = RUN;
      ctr_load   = 1'b1;
    end else begin
      case (state)
        RUN: begin
          ctr_dec = 1'b1;
          if (ctr_is_one) begin
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (expire_rdy) begin
`ifdef PARAM_CONST_TIMER_AUTO_RELOAD_EN
            state_next = RUN;
            ctr_load   = 1'b1;
`else
            state_next = IDLE;
            ctr_clear  = 1'b1;
`endif
          end
        end
        default: state_next = state;
      endcase
    end
  end

  param_down_counter #(
    .nbits(nbits)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .clear      (ctr_clear),
    .load       (ctr_load),
    .load_value (RELOAD),
    .dec        (ctr_dec),
    .count      (count),
    .is_one     (ctr_is_one)
  );

  // Pure decodes of the state register: no path from any input.
  assign running    = (state != IDLE);
  assign expire_val = (state == HOLD);

endmodule

// File: tb/tb_param_const_timer.sv
module tb_param_const_timer;

  localparam int unsigned NB = 4;
  localparam int unsigned VAL = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          stop;
  logic [NB-1:0] count;
  logic          running;
  logic          expire_val;
  logic          expire_rdy;

  typedef struct {
    string         tag;
    logic [NB-1:0] count;
    logic          running;
    logic          ev;
  } exp_t;

  exp_t sb[$];
  int   total  = 0;
  int   passed = 0;

  param_const_timer #(
    .nbits (NB),
    .value (VAL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .count      (count),
    .running    (running),
    .expire_val (expire_val),
    .expire_rdy (expire_rdy)
  );

  always #5 clk = ~clk;

  task automatic push(input string tag, input logic [NB-1:0] c, input logic r, input logic e);
    exp_t x;
    x.tag = tag; x.count = c; x.running = r; x.ev = e;
    sb.push_back(x);
  endtask

  task automatic check_out();
    exp_t x;
    if (sb.size() == 0) begin
      total++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    x = sb.pop_front();
    total++;
    assert (count === x.count) passed++;
    else $error("FAIL %s.count observed=%0d expected=%0d", x.tag, count, x.count);
    total++;
    assert (running === x.running) passed++;
    else $error("FAIL %s.running observed=%b expected=%b", x.tag, running, x.running);
    total++;
    assert (expire_val === x.ev) passed++;
    else $error("FAIL %s.expire_val observed=%b expected=%b", x.tag, expire_val, x.ev);
  endtask

  // Drive inputs for one edge, record the expected post-edge outputs, sample #1 after.
  task automatic step(input logic s, input logic p, input logic r, input string tag,
                      input logic [NB-1:0] c, input logic run, input logic e);
    start = s; stop = p; expire_rdy = r;
    push(tag, c, run, e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; expire_rdy = 1'b0;
    push("reset", '0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check_out();
    reset = 1'b1;
    step(0, 0, 0, "idle", 0, 0, 0);

    // basic count: start then 3,2,1,0 with expire from the 0
    step(1, 0, 0, "load", 3, 1, 0);
    step(0, 0, 0, "c2", 2, 1, 0);
    step(0, 0, 0, "c1", 1, 1, 0);
    step(0, 0, 0, "c0", 0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, "hold", 0, 1, 1);

`ifdef PARAM_CONST_TIMER_AUTO_RELOAD_EN
    step(0, 0, 1, "reload", 3, 1, 0);
    step(0, 0, 0, "r2", 2, 1, 0);
    step(0, 0, 0, "r1", 1, 1, 0);
    step(0, 0, 0, "r0", 0, 1, 1);
    step(0, 0, 1, "reload2", 3, 1, 0);
    step(0, 1, 0, "stop_run", 0, 0, 0);
`else
    step(0, 0, 1, "oneshot", 0, 0, 0);
    step(0, 0, 0, "oneshot_idle", 0, 0, 0);
`endif
    step(0, 0, 1, "rdy_in_idle", 0, 0, 0);

    // stop beats start while count==2
    step(1, 0, 0, "ld_b", 3, 1, 0);
    step(0, 0, 0, "b2", 2, 1, 0);
    step(1, 1, 0, "stop_start", 0, 0, 0);

    // start in HOLD discards the pending expire
    step(1, 0, 0, "ld_c", 3, 1, 0);
    step(0, 0, 0, "c2b", 2, 1, 0);
    step(0, 0, 0, "c1b", 1, 1, 0);
    step(0, 0, 0, "c0b", 0, 1, 1);
    step(1, 0, 0, "restart_hold", 3, 1, 0);
    step(0, 0, 1, "rdy_in_run", 2, 1, 0);
    step(0, 0, 0, "c1c", 1, 1, 0);
    step(0, 0, 0, "c0c", 0, 1, 1);
    step(0, 1, 1, "stop_hold", 0, 0, 0);

    // async reset between edges while running
    step(1, 0, 0, "ld_d", 3, 1, 0);
    step(0, 0, 0, "d2", 2, 1, 0);
    start = 1'b0; stop = 1'b0; expire_rdy = 1'b0;
    #2;
    reset = 1'b0;
    push("async_reset", 0, 0, 0);
    #1;
    check_out();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(0, 0, 0, "post_reset_idle", 0, 0, 0);
    step(1, 0, 0, "post_reset_load", 3, 1, 0);

    if (sb.size() != 0) begin
      total++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
